// File: rtl/prog_clock_divider_if.sv
// Configuration/handshake bundle for prog_clock_divider.
// The DUT takes the slave modport; the driving side takes master.
interface prog_clock_divider_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] high_in;
    logic             ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;

    modport master (
        output en, load, div_in, high_in,
        input  ready, cfg_err, clk_out, tick
    );

    modport slave (
        input  en, load, div_in, high_in,
        output ready, cfg_err, clk_out, tick
    );
endinterface

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock/tick divider; new configs take effect at a period boundary.
// Optional CLKGEN_SYNC_EN adds sync_in, whose rising edge restarts the period.
module prog_clock_divider #(
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 10416,
    parameter int DEF_HIGH = 5208
) (
    input logic                clk_in,
    input logic                rst,
    prog_clock_divider_if.slave bus
`ifdef CLKGEN_SYNC_EN
    ,
    input logic                sync_in
`endif
);

    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEF_HIGH);

    state_t           state, state_n;
    logic [CNT_W-1:0] div_cur, div_cur_n;
    logic [CNT_W-1:0] high_cur, high_cur_n;
    logic [CNT_W-1:0] div_pnd, div_pnd_n;
    logic [CNT_W-1:0] high_pnd, high_pnd_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             clk_out_q, clk_out_n;
    logic             tick_q, tick_n;
    logic             cfg_err_q, cfg_err_n;
    logic             restart;
    logic             at_wrap;
    logic             apply;
    logic             load_ok;

`ifdef CLKGEN_SYNC_EN
    logic sync_q;
    logic sync_rise;

    // Edge seen in cycle N is registered, so the restart lands on the edge ending N+1.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_q    <= 1'b0;
            sync_rise <= 1'b0;
        end else begin
            sync_q    <= sync_in;
            sync_rise <= bus.en & sync_in & ~sync_q;
        end
    end

    assign restart = bus.en & sync_rise;
`else
    assign restart = 1'b0;
`endif

    assign at_wrap = (cnt == div_cur - ONE) || restart;
    assign apply   = (state == PEND) && (!bus.en || at_wrap);
    assign load_ok = (bus.div_in >= TWO) && (bus.high_in != '0) && (bus.high_in < bus.div_in);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= STOP;
            div_cur   <= DIV_RST;
            high_cur  <= HIGH_RST;
            div_pnd   <= '0;
            high_pnd  <= '0;
            cnt       <= DIV_RST - ONE;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            div_cur   <= div_cur_n;
            high_cur  <= high_cur_n;
            div_pnd   <= div_pnd_n;
            high_pnd  <= high_pnd_n;
            cnt       <= cnt_n;
            clk_out_q <= clk_out_n;
            tick_q    <= tick_n;
            cfg_err_q <= cfg_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_cur_n  = div_cur;
        high_cur_n = high_cur;
        div_pnd_n  = div_pnd;
        high_pnd_n = high_pnd;
        cnt_n      = cnt;
        clk_out_n  = 1'b0;
        tick_n     = 1'b0;
        cfg_err_n  = 1'b0;

        // Outputs of the new period are derived from the just-applied config.
        if (apply) begin
            div_cur_n  = div_pnd;
            high_cur_n = high_pnd;
        end

        if (!bus.en) begin
            cnt_n   = div_cur_n - ONE;
            state_n = STOP;
        end else begin
            cnt_n     = at_wrap ? '0 : cnt + ONE;
            clk_out_n = (cnt_n < high_cur_n);
            tick_n    = (cnt_n == '0);
            if (state != PEND || apply) begin
                state_n = RUN;
            end
        end

        if (bus.load) begin
            if (state != PEND && load_ok) begin
                div_pnd_n  = bus.div_in;
                high_pnd_n = bus.high_in;
                state_n    = PEND;
            end else begin
                cfg_err_n = 1'b1;
            end
        end
    end

    assign bus.ready   = (state != PEND);
    assign bus.cfg_err = cfg_err_q;
    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (DEF_DIV=10, DEF_HIGH=5).
// Covers default period, load validation, deferred apply, stop/restart and reset in PEND.
module tb_prog_clock_divider;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
`ifdef CLKGEN_SYNC_EN
    logic sync_in = 1'b0;
`endif

    prog_clock_divider_if #(.CNT_W(16)) bus ();

    prog_clock_divider #(
        .CNT_W   (16),
        .DEF_DIV (10),
        .DEF_HIGH(5)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
`ifdef CLKGEN_SYNC_EN
        ,
        .sync_in(sync_in)
`endif
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Expected period phase and config; sw marks a config that takes over at the next wrap.
    int unsigned ecnt, ediv, ehigh, ndiv, nhigh;
    bit          sw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cyc(input string tag, input logic exp_ready, input logic exp_err);
        step();
        if (ecnt == ediv - 1) begin
            ecnt = 0;
            if (sw) begin
                ediv  = ndiv;
                ehigh = nhigh;
                sw    = 1'b0;
            end
        end else begin
            ecnt++;
        end
        check({tag, ".tick"},    32'(bus.tick),    32'(ecnt == 0));
        check({tag, ".clk_out"}, 32'(bus.clk_out), 32'(ecnt < ehigh));
        check({tag, ".ready"},   32'(bus.ready),   32'(exp_ready));
        check({tag, ".cfg_err"}, 32'(bus.cfg_err), 32'(exp_err));
    endtask

    task automatic stop_cyc(input string tag);
        step();
        ecnt = ediv - 1;
        check({tag, ".tick"},    32'(bus.tick),    32'(0));
        check({tag, ".clk_out"}, 32'(bus.clk_out), 32'(0));
        check({tag, ".ready"},   32'(bus.ready),   32'(1));
    endtask

    task automatic drive_load(input logic ld, input logic [15:0] d, input logic [15:0] h);
        bus.load    = ld;
        bus.div_in  = d;
        bus.high_in = h;
    endtask

    initial begin
        bus.en = 1'b0;
        drive_load(1'b0, 16'd0, 16'd0);
        ediv  = 10;
        ehigh = 5;
        ecnt  = 9;
        sw    = 1'b0;

        #12;
        check("rst.clk_out", 32'(bus.clk_out), 32'(0));
        check("rst.tick",    32'(bus.tick),    32'(0));
        check("rst.cfg_err", 32'(bus.cfg_err), 32'(0));
        check("rst.ready",   32'(bus.ready),   32'(1));
        rst = 1'b1;
        stop_cyc("idle");

        // Default 10-cycle period, 5 high / 5 low, first tick on first enabled edge.
        bus.en = 1'b1;
        for (int i = 0; i < 20; i++) cyc("run10", 1'b1, 1'b0);

        // Rejected loads: div<2, high=0, high=div.
        drive_load(1'b1, 16'd1, 16'd1);
        cyc("bad_div", 1'b1, 1'b1);
        drive_load(1'b0, 16'd0, 16'd0);
        cyc("bad_div_clr", 1'b1, 1'b0);
        drive_load(1'b1, 16'd4, 16'd0);
        cyc("bad_high0", 1'b1, 1'b1);
        drive_load(1'b0, 16'd0, 16'd0);
        cyc("bad_high0_clr", 1'b1, 1'b0);
        drive_load(1'b1, 16'd4, 16'd4);
        cyc("bad_higheq", 1'b1, 1'b1);
        drive_load(1'b0, 16'd0, 16'd0);
        cyc("bad_higheq_clr", 1'b1, 1'b0);

        // Valid load mid-period, then a second load while busy that must be dropped.
        drive_load(1'b1, 16'd4, 16'd1);
        cyc("load_ok", 1'b0, 1'b0);
        ndiv  = 4;
        nhigh = 1;
        sw    = 1'b1;
        drive_load(1'b1, 16'd6, 16'd2);
        cyc("load_busy", 1'b0, 1'b1);
        drive_load(1'b0, 16'd0, 16'd0);
        cyc("pend8", 1'b0, 1'b0);
        cyc("pend9", 1'b0, 1'b0);
        cyc("switch", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc("run4", 1'b1, 1'b0);

        // Stop at cnt=2 for three cycles, then resume.
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) stop_cyc("stop");
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) cyc("resume", 1'b1, 1'b0);

        // Reset while a config is pending: it must be discarded.
        drive_load(1'b1, 16'd6, 16'd3);
        cyc("pend_load", 1'b0, 1'b0);
        drive_load(1'b0, 16'd0, 16'd0);
        #1;
        rst = 1'b0;
        #1;
        check("rst_pend.clk_out", 32'(bus.clk_out), 32'(0));
        check("rst_pend.tick",    32'(bus.tick),    32'(0));
        check("rst_pend.ready",   32'(bus.ready),   32'(1));
        check("rst_pend.cfg_err", 32'(bus.cfg_err), 32'(0));
        ediv  = 10;
        ehigh = 5;
        ecnt  = 9;
        sw    = 1'b0;
        step();
        check("rst_hold.tick", 32'(bus.tick), 32'(0));
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cyc("after_rst", 1'b1, 1'b0);

`ifdef CLKGEN_SYNC_EN
        // Rise seen at cnt=6 restarts the period two cycles later.
        for (int i = 0; i < 7; i++) cyc("pre_sync", 1'b1, 1'b0);
        sync_in = 1'b1;
        cyc("sync_det", 1'b1, 1'b0);
        ecnt = ediv - 1;
        cyc("sync_restart", 1'b1, 1'b0);
        sync_in = 1'b0;
        for (int i = 0; i < 10; i++) cyc("post_sync", 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
